// File: rtl/bus_timer_irq_pkg.sv
// bus_timer_irq_pkg
//   Shared constants for the bus interval timer: register offsets inside the
//   8-byte window, flag bit positions and the STOP/RUN state encoding.
package bus_timer_irq_pkg;

  // Register offsets (address[2:0])
  localparam logic [2:0] TMR_CNTL = 3'd0;  // counter low  / latch low write
  localparam logic [2:0] TMR_CNTH = 3'd1;  // counter high / start
  localparam logic [2:0] TMR_LATL = 3'd2;  // latch low, no side effects
  localparam logic [2:0] TMR_LATH = 3'd3;  // latch high, no side effects
  localparam logic [2:0] TMR_ACR  = 3'd4;  // auxiliary control
  localparam logic [2:0] TMR_PRE  = 3'd5;  // prescale reload value
  localparam logic [2:0] TMR_IFR  = 3'd6;  // interrupt flag
  localparam logic [2:0] TMR_IER  = 3'd7;  // interrupt enable

  // Bit positions inside the flag/control bytes
  localparam int unsigned IFR_BIT     = 32'd0;
  localparam int unsigned IER_BIT     = 32'd0;
  localparam int unsigned IER_SETCLR  = 32'd7;
  localparam int unsigned ACR_FREERUN = 32'd0;

  // Timer state encoding
  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/bus_timer_irq_prescaler.sv
// bus_timer_irq_prescaler
//   Divides the clock by (prescale+1) while the timer runs and emits a
//   one-clock tick when the divider is at zero.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   run         timer is in RUN; divider holds otherwise
//   load        restart request; reloads the divider from prescale
//   prescale    reload value (pre-edge register value)
//   tick        combinational, high on the clock where the divider reaches 0
module bus_timer_irq_prescaler
  import bus_timer_irq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] pcnt_r;
  logic [7:0] pcnt_s;

  assign tick = run & (pcnt_r == 8'd0);

  // Next divider value: restart reload, periodic reload on tick, else count down while running
  always_comb begin
    pcnt_s = pcnt_r;
    if (load) begin
      pcnt_s = prescale;
    end else if (run) begin
      if (pcnt_r == 8'd0) begin
        pcnt_s = prescale;
      end else begin
        pcnt_s = pcnt_r - 8'd1;
      end
    end else begin
      pcnt_s = pcnt_r;
    end
  end

  // Divider register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_r <= 8'd0;
    end else begin
      pcnt_r <= pcnt_s;
    end
  end

endmodule

// File: rtl/bus_timer_irq.sv
// bus_timer_irq
//   Memory-mapped 16-bit interval timer and level interrupt source on the
//   6502-style address/data bus. Reads return data in the same cycle the
//   address is presented; writes commit on the rising clock edge.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   address     CPU bus address
//   write       1 = write cycle
//   data_i      write data from the CPU
//   data_o      read data to the CPU, 8'h00 unless a read hits the window
//   sel         combinational window hit
//   irq         level interrupt = IFR & IER (register derived only)
module bus_timer_irq
  import bus_timer_irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD000
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        sel,
  output logic        irq
);

  logic [0:0]  state_r,   state_s;
  logic [15:0] counter_r, counter_s;
  logic [15:0] latch_r,   latch_s;
  logic [7:0]  prescale_r, prescale_s;
  logic        acr_r, acr_s;
  logic        ifr_r, ifr_s;
  logic        ier_r, ier_s;

  logic        rd_s, wr_s, start_s, run_s, tick_s, underflow_s, clr_s;
  logic [2:0]  off_s;

  assign sel     = (address[15:3] == BASE_ADDR[15:3]);
  assign off_s   = address[2:0];
  assign rd_s    = sel & ~write;
  assign wr_s    = sel & write;
  assign start_s = wr_s & (off_s == TMR_CNTH);
  assign run_s   = (state_r == ST_RUN);
  assign irq     = ifr_r & ier_r;

  // Underflow is a tick while the counter already sits at zero
  assign underflow_s = tick_s & (counter_r == 16'd0);
  // Software flag clears: counter-low read or IFR write with bit0 set
  assign clr_s = (rd_s & (off_s == TMR_CNTL)) |
                 (wr_s & (off_s == TMR_IFR) & data_i[IFR_BIT]);

  bus_timer_irq_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .run      (run_s),
    .load     (start_s),
    .prescale (prescale_r),
    .tick     (tick_s)
  );

  // Counter, state and flag next-state with collision priority:
  // start beats underflow, underflow set beats software clear
  always_comb begin
    counter_s = counter_r;
    state_s   = state_r;
    ifr_s     = ifr_r;
    if (start_s) begin
      counter_s = {data_i, latch_r[7:0]};
      state_s   = ST_RUN;
      ifr_s     = 1'b0;
    end else if (underflow_s) begin
      ifr_s = 1'b1;
      if (acr_r) begin
        counter_s = latch_r;  // pre-edge latch even if latch is written now
      end else begin
        state_s = ST_STOP;
      end
    end else begin
      if (tick_s) begin
        counter_s = counter_r - 16'd1;
      end else begin
        counter_s = counter_r;
      end
      if (clr_s) begin
        ifr_s = 1'b0;
      end else begin
        ifr_s = ifr_r;
      end
    end
  end

  // Plain register writes: latch, ACR, PRESCALE, IER
  always_comb begin
    latch_s    = latch_r;
    acr_s      = acr_r;
    prescale_s = prescale_r;
    ier_s      = ier_r;
    if (wr_s) begin
      case (off_s)
        TMR_CNTL, TMR_LATL: latch_s[7:0]  = data_i;
        TMR_CNTH, TMR_LATH: latch_s[15:8] = data_i;
        TMR_ACR:            acr_s         = data_i[ACR_FREERUN];
        TMR_PRE:            prescale_s    = data_i;
        TMR_IER: begin
          // Only bit0 exists; it is touched only when selected by data_i[0]
          if (data_i[IER_BIT]) begin
            ier_s = data_i[IER_SETCLR];
          end else begin
            ier_s = ier_r;
          end
        end
        default: latch_s = latch_r;
      endcase
    end else begin
      latch_s = latch_r;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_STOP;
      counter_r  <= 16'd0;
      latch_r    <= 16'd0;
      prescale_r <= 8'd0;
      acr_r      <= 1'b0;
      ifr_r      <= 1'b0;
      ier_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      counter_r  <= counter_s;
      latch_r    <= latch_s;
      prescale_r <= prescale_s;
      acr_r      <= acr_s;
      ifr_r      <= ifr_s;
      ier_r      <= ier_s;
    end
  end

  // Same-cycle read mux; counter reads show the pre-edge value
  always_comb begin
    data_o = 8'h00;
    if (rd_s) begin
      case (off_s)
        TMR_CNTL: data_o = counter_r[7:0];
        TMR_CNTH: data_o = counter_r[15:8];
        TMR_LATL: data_o = latch_r[7:0];
        TMR_LATH: data_o = latch_r[15:8];
        TMR_ACR:  data_o = {7'd0, acr_r};
        TMR_PRE:  data_o = prescale_r;
        TMR_IFR:  data_o = {irq, 6'd0, ifr_r};
        TMR_IER:  data_o = {1'b1, 6'd0, ier_r};
        default:  data_o = 8'h00;
      endcase
    end else begin
      data_o = 8'h00;
    end
  end

endmodule

// File: tb/tb_bus_timer_irq.sv
// tb_bus_timer_irq
//   Scoreboard bench: each issued bus cycle pushes the expected sel/data_o/irq
//   computed by a behavioural timer model; a monitor pops and compares.
module tb_bus_timer_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic        write = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  data_o;
  logic        sel;
  logic        irq;

  int checks = 0;
  int errors = 0;

  bus_timer_irq #(.BASE_ADDR(16'hD000)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .data_i(data_i), .data_o(data_o), .sel(sel), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [7:0]  data;
    logic        irq;
    logic [15:0] addr;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: plain integers following the register rules
  int m_cnt, m_latch, m_pre, m_div;
  bit m_free, m_ifr, m_ier, m_run;

  task automatic m_reset();
    m_cnt = 0; m_latch = 0; m_pre = 0; m_div = 0;
    m_free = 0; m_ifr = 0; m_ier = 0; m_run = 0;
  endtask

  function automatic bit m_hit(input logic [15:0] a);
    return (a >= 16'hD000) && (a <= 16'hD007);
  endfunction

  function automatic bit m_uf_now();
    return m_run && (m_div == 0) && (m_cnt == 0);
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a, input logic w);
    int off;
    if (!m_hit(a) || w) return 8'h00;
    off = int'(a) - 16'hD000;
    case (off)
      0: return 8'(m_cnt % 256);
      1: return 8'(m_cnt / 256);
      2: return 8'(m_latch % 256);
      3: return 8'(m_latch / 256);
      4: return m_free ? 8'h01 : 8'h00;
      5: return 8'(m_pre);
      6: return {(m_ifr & m_ier), 6'd0, m_ifr};
      default: return {1'b1, 6'd0, m_ier};
    endcase
  endfunction

  // Advance the model across one clock edge for the given bus op
  task automatic m_edge(input logic [15:0] a, input logic w, input logic [7:0] d);
    int  off, old_latch;
    bit  tick, uf, clear;
    old_latch = m_latch;
    off   = m_hit(a) ? int'(a) - 16'hD000 : -1;
    tick  = m_run && (m_div == 0);
    uf    = tick && (m_cnt == 0);
    clear = (off == 0 && !w) || (off == 6 && w && d[0]);
    if (m_run) m_div = tick ? m_pre : m_div - 1;
    if (tick) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else begin
        m_ifr = 1;
        if (m_free) m_cnt = old_latch;
        else m_run = 0;
      end
    end
    if (clear && !uf) m_ifr = 0;
    if (w) begin
      case (off)
        0, 2: m_latch = (m_latch / 256) * 256 + int'(d);
        3:    m_latch = int'(d) * 256 + (m_latch % 256);
        1: begin
          m_latch = int'(d) * 256 + (old_latch % 256);
          m_cnt   = int'(d) * 256 + (old_latch % 256);
          m_div   = m_pre;
          m_run   = 1;
          m_ifr   = 0;
        end
        4: m_free = d[0];
        5: m_pre  = int'(d);
        7: if (d[0]) m_ier = d[7];
        default: ;
      endcase
    end
  endtask

  // Issue one bus cycle: drive, queue expectation, step model
  task automatic cycle(input logic [15:0] a, input logic w, input logic [7:0] d, input logic r);
    exp_t e;
    @(posedge clk); #2;
    address = a; write = w; data_i = d; reset = r;
    if (r) m_reset();
    e.sel  = m_hit(a);
    e.data = m_read(a, w);
    e.irq  = m_ifr & m_ier;
    e.addr = a;
    sb.push_back(e);
    if (!r) m_edge(a, w, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(16'h0000, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_underflow(input int maxc);
    int k;
    k = 0;
    while (!m_uf_now() && k < maxc) begin
      cycle(16'h0000, 1'b0, 8'h00, 1'b0);
      k++;
    end
    if (!m_uf_now()) begin
      errors++;
      $display("FAIL wait_underflow: no underflow within %0d cycles (required underflow)", maxc);
    end
  endtask

  // Monitor: outputs are stable from drive time to the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 3;
      if (sel !== e.sel) begin
        errors++;
        $display("FAIL sel @%h: got %b want %b", e.addr, sel, e.sel);
      end
      if (data_o !== e.data) begin
        errors++;
        $display("FAIL data_o @%h: got %h want %h", e.addr, data_o, e.data);
      end
      if (irq !== e.irq) begin
        errors++;
        $display("FAIL irq @%h: got %b want %b", e.addr, irq, e.irq);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, off;
    logic [7:0] d;
    logic [15:0] a;
    m_reset();
    cycle(16'h0000, 1'b0, 8'h00, 1'b1);
    cycle(16'h0000, 1'b0, 8'h00, 1'b1);
    // T1: reset-state reads of every offset
    for (int i = 0; i < 8; i++) cycle(16'hD000 + 16'(i), 1'b0, 8'h00, 1'b0);

    // T2: one-shot, counter 3 down to 0 then flag
    cycle(16'hD007, 1'b1, 8'h81, 1'b0);
    cycle(16'hD005, 1'b1, 8'h00, 1'b0);
    cycle(16'hD004, 1'b1, 8'h00, 1'b0);
    cycle(16'hD000, 1'b1, 8'h03, 1'b0);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(16'hD001 - 16'(i % 2), 1'b0, 8'h00, 1'b0);
    cycle(16'hD006, 1'b0, 8'h00, 1'b0);
    cycle(16'hD006, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 6; i++) cycle(16'hD006, 1'b0, 8'h00, 1'b0);

    // T1 again: reset in the middle of a running count
    cycle(16'hD001, 1'b1, 8'h00, 1'b0);
    cycle(16'hD000, 1'b0, 8'h00, 1'b0);
    cycle(16'hD006, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) cycle(16'hD000 + 16'(i), 1'b0, 8'h00, 1'b0);

    // T3: free-run, prescale 1, latch 2, period 6
    cycle(16'hD007, 1'b1, 8'h81, 1'b0);
    cycle(16'hD004, 1'b1, 8'h01, 1'b0);
    cycle(16'hD005, 1'b1, 8'h01, 1'b0);
    cycle(16'hD000, 1'b1, 8'h02, 1'b0);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cycle(16'hD006, 1'b0, 8'h00, 1'b0);
    cycle(16'hD006, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) cycle(16'hD006, 1'b0, 8'h00, 1'b0);

    // T4: clears on the underflow edge lose to the set
    wait_underflow(20);
    cycle(16'hD006, 1'b1, 8'h01, 1'b0);
    cycle(16'hD006, 1'b0, 8'h00, 1'b0);
    wait_underflow(20);
    cycle(16'hD000, 1'b0, 8'h00, 1'b0);
    cycle(16'hD006, 1'b0, 8'h00, 1'b0);

    // T5: decode edges
    cycle(16'hD008, 1'b0, 8'h00, 1'b0);
    cycle(16'hCFFF, 1'b0, 8'h00, 1'b0);
    cycle(16'hD008, 1'b1, 8'h55, 1'b0);
    cycle(16'hCFFE, 1'b1, 8'h01, 1'b0);
    cycle(16'hD006, 1'b0, 8'h00, 1'b0);
    cycle(16'hD005, 1'b0, 8'h00, 1'b0);

    // T6: restart on the underflow edge, with new latch low
    cycle(16'hD002, 1'b1, 8'h05, 1'b0);
    wait_underflow(20);
    cycle(16'hD001, 1'b1, 8'h00, 1'b0);
    cycle(16'hD006, 1'b0, 8'h00, 1'b0);
    cycle(16'hD000, 1'b0, 8'h00, 1'b0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        cycle(16'h0000, 1'b0, 8'h00, 1'b1);
      end else if (r < 70) begin
        a = 16'($urandom_range(0, 32'hCFFF));
        cycle(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
      end else begin
        off = $urandom_range(0, 7);
        case (off)
          0, 2:    d = 8'($urandom_range(0, 7));
          1, 3:    d = ($urandom_range(0, 19) == 0) ? 8'h01 : 8'h00;
          5:       d = 8'($urandom_range(0, 3));
          default: d = 8'($urandom_range(0, 255));
        endcase
        // keep restarts rare so underflows occur
        if (off == 1 && $urandom_range(0, 3) != 0)
          cycle(16'hD001, 1'b0, 8'h00, 1'b0);
        else
          cycle(16'hD000 + 16'(off), 1'($urandom_range(0, 2) == 0), d, 1'b0);
      end
    end

    idle(2);
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
